// File: rtl/exe_sched_pkg.sv
// Shared types and default sizes for the execute-stage issue scoreboard.
package exe_sched_pkg;

    localparam int NUM_REGS_DEF     = 32;
    localparam int REG_IDX_W_DEF    = 5;
    localparam int MAX_INFLIGHT_DEF = 4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/scoreboard_hazard_check.sv
// Combinational RAW/WAW hazard detection against the busy vector, with the
// register retiring this cycle already released.
module scoreboard_hazard_check
    import exe_sched_pkg::*;
#(
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF
) (
    input  logic [NUM_REGS-1:0]  busy_vec,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_dst,
    input  logic                 uses_a,
    input  logic [REG_IDX_W-1:0] src_a,
    input  logic                 uses_b,
    input  logic [REG_IDX_W-1:0] src_b,
    input  logic                 writes,
    input  logic [REG_IDX_W-1:0] dst,
    output logic                 hazard
);

    logic [NUM_REGS-1:0] eff_busy;

    always_comb begin
        eff_busy = busy_vec;
        if (wb_valid) eff_busy[wb_dst] = 1'b0;
        // r0 is hardwired zero and can never be pending.
        eff_busy[0] = 1'b0;
        hazard = (uses_a & eff_busy[src_a])
               | (uses_b & eff_busy[src_b])
               | (writes & eff_busy[dst]);
    end

endmodule

// File: rtl/exe_issue_scoreboard.sv
// Issue controller in front of execute: tracks in-flight register writes,
// stalls dependent instructions and drains on flush.
// Optional stall counter output enabled by EXE_SCOREBOARD_STALL_CNT_EN.
module exe_issue_scoreboard
    import exe_sched_pkg::*;
#(
    parameter int NUM_REGS     = NUM_REGS_DEF,
    parameter int REG_IDX_W    = REG_IDX_W_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int CNT_W        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [REG_IDX_W-1:0] issue_src_a,
    input  logic [REG_IDX_W-1:0] issue_src_b,
    input  logic                 issue_uses_a,
    input  logic                 issue_uses_b,
    input  logic [REG_IDX_W-1:0] issue_dst,
    input  logic                 issue_writes,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_dst,
    input  logic                 flush,
    output logic                 exe_en,
    output logic [NUM_REGS-1:0]  busy_vec,
    output logic [CNT_W-1:0]     inflight_cnt,
`ifdef EXE_SCOREBOARD_STALL_CNT_EN
    output logic [31:0]          stall_cycles,
`endif
    output logic                 draining,
    output logic                 wb_err
);

    state_t              state;
    logic                hazard;
    logic                cnt_full;
    logic                set_en;
    logic                wb_hit;
    logic [NUM_REGS-1:0] busy_next;

    scoreboard_hazard_check #(
        .NUM_REGS  (NUM_REGS),
        .REG_IDX_W (REG_IDX_W)
    ) u_hazard (
        .busy_vec (busy_vec),
        .wb_valid (wb_valid),
        .wb_dst   (wb_dst),
        .uses_a   (issue_uses_a),
        .src_a    (issue_src_a),
        .uses_b   (issue_uses_b),
        .src_b    (issue_src_b),
        .writes   (issue_writes),
        .dst      (issue_dst),
        .hazard   (hazard)
    );

    // Slot check uses the registered count; a same-cycle writeback frees nothing.
    assign cnt_full    = (inflight_cnt == CNT_W'(MAX_INFLIGHT));
    assign issue_ready = (state == RUN) && !flush && !hazard
                       && !(issue_writes && (issue_dst != '0) && cnt_full);
    assign exe_en      = issue_valid & issue_ready;
    assign set_en      = exe_en && issue_writes && (issue_dst != '0);
    assign wb_hit      = wb_valid && (wb_dst != '0) && busy_vec[wb_dst];
    assign draining    = (state == DRAIN);

    // Clear before set so a same-register issue/writeback pair leaves the bit set.
    always_comb begin
        busy_next = busy_vec;
        if (wb_hit) busy_next[wb_dst] = 1'b0;
        if (set_en) busy_next[issue_dst] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_vec     <= '0;
            inflight_cnt <= '0;
            state        <= RUN;
            wb_err       <= 1'b0;
        end else begin
            busy_vec <= busy_next;
            if (set_en && !wb_hit)
                inflight_cnt <= inflight_cnt + CNT_W'(1);
            else if (!set_en && wb_hit)
                inflight_cnt <= inflight_cnt - CNT_W'(1);
            if (wb_valid && !wb_hit) wb_err <= 1'b1;
            case (state)
                RUN:     if (flush) state <= DRAIN;
                DRAIN:   if ((inflight_cnt == '0) && !flush) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef EXE_SCOREBOARD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            stall_cycles <= '0;
        else if (issue_valid && !issue_ready && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(set_en && !wb_hit && cnt_full))
                else $error("inflight_cnt increment beyond MAX_INFLIGHT");
            assert (!(wb_hit && !set_en && (inflight_cnt == '0)))
                else $error("inflight_cnt decrement below zero");
        end
    end

endmodule

// File: tb/tb_exe_issue_scoreboard.sv
// Directed scoreboard bench for exe_issue_scoreboard: the driver queues
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_exe_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_src_a, issue_src_b, issue_dst, wb_dst;
    logic        issue_uses_a, issue_uses_b, issue_writes;
    logic        wb_valid, flush, exe_en, draining, wb_err;
    logic [31:0] busy_vec;
    logic [2:0]  inflight_cnt;
`ifdef EXE_SCOREBOARD_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    typedef struct {
        string       nm;
        logic        rdy;
        logic        en;
        logic [31:0] busy;
        logic [2:0]  cnt;
        logic        drn;
        logic        err;
        logic [31:0] stall;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   stall_acc = 0;

    always #5 clk = ~clk;

    exe_issue_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_src_a  (issue_src_a),
        .issue_src_b  (issue_src_b),
        .issue_uses_a (issue_uses_a),
        .issue_uses_b (issue_uses_b),
        .issue_dst    (issue_dst),
        .issue_writes (issue_writes),
        .wb_valid     (wb_valid),
        .wb_dst       (wb_dst),
        .flush        (flush),
        .exe_en       (exe_en),
        .busy_vec     (busy_vec),
        .inflight_cnt (inflight_cnt),
`ifdef EXE_SCOREBOARD_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .draining     (draining),
        .wb_err       (wb_err)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Monitor: one queued expectation per driven cycle, checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.nm, ".ready"}, {31'd0, issue_ready}, {31'd0, e.rdy});
                chk({e.nm, ".exe_en"}, {31'd0, exe_en}, {31'd0, e.en});
                chk({e.nm, ".busy"}, busy_vec, e.busy);
                chk({e.nm, ".cnt"}, {29'd0, inflight_cnt}, {29'd0, e.cnt});
                chk({e.nm, ".draining"}, {31'd0, draining}, {31'd0, e.drn});
                chk({e.nm, ".wb_err"}, {31'd0, wb_err}, {31'd0, e.err});
`ifdef EXE_SCOREBOARD_STALL_CNT_EN
                chk({e.nm, ".stall"}, stall_cycles, e.stall);
`endif
            end
        end
    end

    // Drive one cycle of inputs and queue the values expected during it.
    task automatic step(input string nm, input logic v,
                        input logic [4:0] sa, input logic ua,
                        input logic [4:0] sb, input logic ub,
                        input logic [4:0] d, input logic w,
                        input logic wbv, input logic [4:0] wbd, input logic fl,
                        input logic er, input logic [31:0] eb, input logic [2:0] ec,
                        input logic ed, input logic ee);
        exp_t e;
        issue_valid  = v;
        issue_src_a  = sa;
        issue_uses_a = ua;
        issue_src_b  = sb;
        issue_uses_b = ub;
        issue_dst    = d;
        issue_writes = w;
        wb_valid     = wbv;
        wb_dst       = wbd;
        flush        = fl;
        e.nm = nm; e.rdy = er; e.en = v & er; e.busy = eb; e.cnt = ec;
        e.drn = ed; e.err = ee; e.stall = stall_acc;
        q.push_back(e);
        if (v && !er) stall_acc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        issue_valid = 0; issue_src_a = 0; issue_src_b = 0; issue_uses_a = 0;
        issue_uses_b = 0; issue_dst = 0; issue_writes = 0;
        wb_valid = 0; wb_dst = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        //    name       v  sa ua sb ub  d  w  wbv wbd fl  rdy busy       cnt drn err
        step("reset",    0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  1, 32'h0,    0,  0,  0);
        step("iss_d3",   1, 0, 0, 0, 0,  3, 1, 0,  0,  0,  1, 32'h0,    0,  0,  0);
        step("raw_a3",   1, 3, 1, 0, 0,  0, 0, 0,  0,  0,  0, 32'h8,    1,  0,  0);
        step("raw_wb3",  1, 3, 1, 0, 0,  0, 0, 1,  3,  0,  1, 32'h8,    1,  0,  0);
        step("after_wb", 0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  1, 32'h0,    0,  0,  0);
        step("iss_d1",   1, 0, 0, 0, 0,  1, 1, 0,  0,  0,  1, 32'h0,    0,  0,  0);
        step("iss_d2",   1, 0, 0, 0, 0,  2, 1, 0,  0,  0,  1, 32'h2,    1,  0,  0);
        step("iss_d4",   1, 0, 0, 0, 0,  4, 1, 0,  0,  0,  1, 32'h6,    2,  0,  0);
        step("iss_d5",   1, 0, 0, 0, 0,  5, 1, 0,  0,  0,  1, 32'h16,   3,  0,  0);
        step("full_d6",  1, 0, 0, 0, 0,  6, 1, 0,  0,  0,  0, 32'h36,   4,  0,  0);
        step("full_wb1", 1, 0, 0, 0, 0,  7, 1, 1,  1,  0,  0, 32'h36,   4,  0,  0);
        step("iss_d7",   1, 0, 0, 0, 0,  7, 1, 0,  0,  0,  1, 32'h34,   3,  0,  0);
        step("wb2",      0, 0, 0, 0, 0,  0, 0, 1,  2,  0,  1, 32'hB4,   4,  0,  0);
        step("wb4",      0, 0, 0, 0, 0,  0, 0, 1,  4,  0,  1, 32'hB0,   3,  0,  0);
        step("wb5",      0, 0, 0, 0, 0,  0, 0, 1,  5,  0,  1, 32'hA0,   2,  0,  0);
        step("wb7",      0, 0, 0, 0, 0,  0, 0, 1,  7,  0,  1, 32'h80,   1,  0,  0);
        step("iss_d0",   1, 0, 0, 0, 0,  0, 1, 0,  0,  0,  1, 32'h0,    0,  0,  0);
        step("rd_r0",    1, 0, 1, 0, 0,  0, 0, 0,  0,  0,  1, 32'h0,    0,  0,  0);
        step("r0_idle",  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  1, 32'h0,    0,  0,  0);
        step("iss_d8",   1, 0, 0, 0, 0,  8, 1, 0,  0,  0,  1, 32'h0,    0,  0,  0);
        step("waw_wb8",  1, 0, 0, 0, 0,  8, 1, 1,  8,  0,  1, 32'h100,  1,  0,  0);
        step("wb8",      0, 0, 0, 0, 0,  0, 0, 1,  8,  0,  1, 32'h100,  1,  0,  0);
        step("d8_idle",  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  1, 32'h0,    0,  0,  0);
        step("fl_d1",    1, 0, 0, 0, 0,  1, 1, 0,  0,  0,  1, 32'h0,    0,  0,  0);
        step("fl_d2",    1, 0, 0, 0, 0,  2, 1, 0,  0,  0,  1, 32'h2,    1,  0,  0);
        step("flush",    1, 0, 0, 0, 0,  3, 1, 0,  0,  1,  0, 32'h6,    2,  0,  0);
        step("drain0",   1, 0, 0, 0, 0,  3, 1, 0,  0,  0,  0, 32'h6,    2,  1,  0);
        step("drn_wb1",  0, 0, 0, 0, 0,  0, 0, 1,  1,  0,  0, 32'h6,    2,  1,  0);
        step("drn_wb2",  0, 0, 0, 0, 0,  0, 0, 1,  2,  0,  0, 32'h4,    1,  1,  0);
        step("drn_last", 1, 0, 0, 0, 0,  3, 1, 0,  0,  0,  0, 32'h0,    0,  1,  0);
        step("run_d3",   1, 0, 0, 0, 0,  3, 1, 0,  0,  0,  1, 32'h0,    0,  0,  0);
        step("run_wb3",  0, 0, 0, 0, 0,  0, 0, 1,  3,  0,  1, 32'h8,    1,  0,  0);
        step("flush2",   0, 0, 0, 0, 0,  0, 0, 0,  0,  1,  0, 32'h0,    0,  0,  0);
        step("fl_in_drn",0, 0, 0, 0, 0,  0, 0, 0,  0,  1,  0, 32'h0,    0,  1,  0);
        step("drn_exit", 0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  0, 32'h0,    0,  1,  0);
        step("run_again",0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  1, 32'h0,    0,  0,  0);
        step("bad_wb9",  0, 0, 0, 0, 0,  0, 0, 1,  9,  0,  1, 32'h0,    0,  0,  0);
        step("err_set",  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  1, 32'h0,    0,  0,  1);
        step("bad_wb0",  0, 0, 0, 0, 0,  0, 0, 1,  0,  0,  1, 32'h0,    0,  0,  1);
        step("err_stick",0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  1, 32'h0,    0,  0,  1);
        step("iss_d10",  1, 0, 0, 0, 0, 10, 1, 0,  0,  0,  1, 32'h0,    0,  0,  1);
        for (int i = 0; i < 5; i++)
            step("stall_b",  1, 0, 0, 10, 1, 0, 0, 0,  0,  0,  0, 32'h400,  1,  0,  1);
        step("wb10",     0, 0, 0, 0, 0,  0, 0, 1, 10,  0,  1, 32'h400,  1,  0,  1);
        step("final",    0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  1, 32'h0,    0,  0,  1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain_queue got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exe_issue_scoreboard.md
Name: exe_issue_scoreboard

Overview:
- Issue controller in front of the execute stage.
- Tracks which architectural registers have a write in flight through execute and writeback; holds off dependent instructions until their operands are written back.
- Drives the stall/enable for the decode→execute pipeline registers.
- On a pipeline flush, drains all in-flight writes before accepting new issues.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
- REG_IDX_W, 5, register index width; must equal clog2(NUM_REGS).
- MAX_INFLIGHT, 4, maximum outstanding register-writing instructions.
- CNT_W, 3, in-flight counter width; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  controller accepts it this cycle (combinational).
- issue_src_a  in  REG_IDX_W  operand A index.
- issue_src_b  in  REG_IDX_W  operand B index.
- issue_uses_a  in  1  operand A is read.
- issue_uses_b  in  1  operand B is read.
- issue_dst  in  REG_IDX_W  destination index.
- issue_writes  in  1  instruction writes issue_dst.
- wb_valid  in  1  writeback retiring a register write.
- wb_dst  in  REG_IDX_W  register being written back.
- flush  in  1  one-cycle flush request.
- exe_en  out  1  enable for the decode→execute pipeline registers; equals issue_valid & issue_ready.
- busy_vec  out  NUM_REGS  per-register pending-write bits (registered).
- inflight_cnt  out  CNT_W  outstanding writes (registered).
- draining  out  1  high while in DRAIN (registered state decode).
- wb_err  out  1  sticky: writeback to a register that was not busy.

Behaviour:
- Reset (rst==0 at a clock edge): busy_vec=0, inflight_cnt=0, state=RUN, wb_err=0; if compiled in, stall_cycles=0. Reset overrides all other events in that cycle.
- Effective busy for the hazard check: busy_vec with bit wb_dst cleared when wb_valid is high. Same-cycle writeback releases the consumer with zero added latency.
- Hazard is asserted when any of the following holds against effective busy:
  - issue_uses_a and src_a is busy;
  - issue_uses_b and src_b is busy;
  - issue_writes and dst is busy (WAW).
- Index 0 is never busy: writes to dst 0 set no bit and do not count toward inflight_cnt.
- issue_ready = state==RUN & !flush & !hazard & !(issue_writes & dst!=0 & inflight_cnt==MAX_INFLIGHT).
  - The inflight_cnt==MAX_INFLIGHT check uses the registered count; a same-cycle writeback does not free a slot.
- Accepted issue with a writing dst≠0: set busy[dst] next cycle; inflight_cnt +1.
- Writeback with busy[wb_dst]=1: clear the bit; inflight_cnt −1.
- Writeback with busy[wb_dst]=0 or wb_dst=0: ignored; set wb_err (sticky until reset).
- Simultaneous issue and writeback: the counter changes by net 0. If both target the same register, the set wins and the bit stays 1.
- State machine:
  - RUN: flush → DRAIN.
  - DRAIN: issue_ready=0. → RUN when the registered inflight_cnt==0 and flush==0; otherwise stay.
  - flush in DRAIN keeps DRAIN. flush is ignored beyond that.
  - Writebacks continue to be processed in DRAIN.
- Latency: issue-to-busy visible is 1 cycle. A writeback releases a waiting consumer in the same cycle.
- Counter never wraps; an increment at MAX or a decrement at 0 cannot occur by construction. An assertion covers both.

Optional Feature:
- Macro EXE_SCOREBOARD_STALL_CNT_EN.
- When defined: adds output stall_cycles (32 bits), which increments every cycle with issue_valid & !issue_ready and saturates at all-ones. It is cleared only by reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package exe_sched_pkg holds:
  - state enum (RUN=0, DRAIN=1);
  - REG_IDX_W and NUM_REGS defaults;
  - MAX_INFLIGHT default.
- One natural sub-module: scoreboard_hazard_check. It is purely combinational: effective-busy masking plus the A/B/WAW compare, producing hazard.
- The parent holds the state machine, counters and busy register.

Test Plan:
- Reset, then issue {dst=3, writes}, then issue {src_a=3, uses_a} next cycle → second instruction ready=0; busy_vec=0x8, inflight_cnt=1.
- In the same stalled cycle, wb_valid with wb_dst=3 → ready=1 that cycle; next cycle busy_vec=0, inflight_cnt=0.
- Issue dst=1,2,4,5 back-to-back, then a writer with dst=6 → fifth ready=0 (cnt=4). Simultaneous issue dst=7 with wb dst=1 also stays ready=0; a cycle later, cnt=3 → dst=7 accepted.
- Issue dst=0 writer and src_a=0 reader → both accepted immediately; busy_vec stays 0, cnt stays 0.
- Two writes in flight, pulse flush → draining=1 and ready=0 until both writebacks retire. state=RUN the cycle after cnt reaches 0; an issue presented together with flush is not accepted.
- wb_valid with wb_dst=9 while busy_vec=0 → wb_err=1 and stays 1; cnt unchanged. With EXE_SCOREBOARD_STALL_CNT_EN, 5 stalled valid cycles → stall_cycles=5.
